// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream, writes 14-bit words to
// program memory and holds the CPU in reset until a length- and checksum-verified load completes.
module prog_loader #(
  parameter int ADDR_W      = 11,
  parameter int MAX_WORDS   = 2048,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [13:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0]   MAX_N  = 16'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LEN_H, S_LEN_L, S_W_HI, S_W_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [7:0]    len_h;
  logic [15:0]   len;
  logic [5:0]    hi_bits;
  logic [7:0]    chk_acc;
  logic [TW-1:0] tcnt;

  logic        xfer;
  logic        abort;
  logic        last_word;
  logic [15:0] n_in;

  assign xfer      = in_valid & in_ready;
  assign n_in      = {len_h, in_data};
  assign last_word = ((16'(word_count) + 16'd1) == len);

  // Any bad byte or an idle stretch reaching the timeout ends the load in ERR.
  always_comb begin
    abort = 1'b0;
    if (xfer) begin
      case (state)
        S_HDR:   abort = (in_data != 8'hA5);
        S_LEN_L: abort = (n_in == 16'd0) || (n_in > MAX_N);
        S_W_HI:  abort = (in_data[7:6] != 2'b00);
        S_CHK:   abort = (in_data != chk_acc);
        default: abort = 1'b0;
      endcase
    end else if (in_ready && (tcnt == T_LAST)) begin
      abort = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      tcnt       <= '0;
    end else begin
      mem_we <= 1'b0;
      // in_ready is high exactly in the byte-waiting busy states, so WRITE never counts as idle
      if (xfer) tcnt <= '0;
      else if (in_ready) tcnt <= tcnt + 1'b1;

      if (abort) begin
        state    <= S_ERR;
        in_ready <= 1'b0;
        busy     <= 1'b0;
        err      <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
              state      <= S_HDR;
              in_ready   <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              err        <= 1'b0;
              cpu_rst    <= 1'b1;
              word_count <= '0;
              mem_addr   <= '0;
              chk_acc    <= '0;
              tcnt       <= '0;
            end
          end
          S_HDR: begin
            if (xfer) state <= S_LEN_H;
          end
          S_LEN_H: begin
            if (xfer) begin
              len_h <= in_data;
              state <= S_LEN_L;
            end
          end
          S_LEN_L: begin
            if (xfer) begin
              len   <= n_in;
              state <= S_W_HI;
            end
          end
          S_W_HI: begin
            if (xfer) begin
              hi_bits <= in_data[5:0];
              chk_acc <= chk_acc ^ in_data;
              state   <= S_W_LO;
            end
          end
          S_W_LO: begin
            if (xfer) begin
              mem_wdata <= {hi_bits, in_data};
              chk_acc   <= chk_acc ^ in_data;
              mem_we    <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end
          end
          S_WRITE: begin
            word_count <= word_count + 1'b1;
            in_ready   <= 1'b1;
            // The address stops at N-1 after the final word so it never wraps.
            if (last_word) begin
              state <= S_CHK;
            end else begin
              mem_addr <= mem_addr + 1'b1;
              state    <= S_W_HI;
            end
          end
          S_CHK: begin
            if (xfer) begin
              state    <= S_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_rst  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
